// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: permutes the 256-byte S RAM in place through a single RAM port.
// Optional macro RC4_KSA_INIT_EN adds a built-in S[k]=k fill before scheduling starts.
module rc4_ksa_engine #(
  parameter int KEY_BYTES  = 3,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   done
);

  localparam int              KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]   KIDX_LAST = KW'(KEY_BYTES - 1);
  localparam logic [1:0]      WAIT_LAST = 2'(MEM_RD_LAT - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef RC4_KSA_INIT_EN
    ST_INIT,
`endif
    ST_RD_SI,
    ST_WT_SI,
    ST_RD_SJ,
    ST_WT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   wren_q, wren_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             key_byte_s;
  logic [7:0]             j_new_s;

  // Key byte selected by the key index; index 0 is the most significant byte.
  always_comb begin
    key_byte_s = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_byte_s = (kidx_q == KW'(b)) ? key_q[8*(KEY_BYTES-1-b) +: 8] : key_byte_s;
    end
  end

  assign j_new_s = j_q + s_q + key_byte_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      kidx_q  <= '0;
      wcnt_q  <= 2'd0;
      key_q   <= '0;
      si_q    <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      wcnt_q  <= wcnt_d;
      key_q   <= key_d;
      si_q    <= si_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; RAM outputs are registered with the values for the state being entered.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    wcnt_d  = wcnt_q;
    key_d   = key_q;
    si_d    = si_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d  = secret_key;
          i_d    = 8'h00;
          j_d    = 8'h00;
          kidx_d = '0;
          wcnt_d = 2'd0;
          busy_d = 1'b1;
          addr_d = 8'h00;
          data_d = 8'h00;
`ifdef RC4_KSA_INIT_EN
          state_d = ST_INIT;
          wren_d  = 1'b1;
`else
          state_d = ST_RD_SI;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef RC4_KSA_INIT_EN
      ST_INIT: begin
        if (i_q == 8'd255) begin
          state_d = ST_RD_SI;
          i_d     = 8'h00;
          addr_d  = 8'h00;
          data_d  = 8'h00;
        end else begin
          i_d    = i_q + 8'd1;
          addr_d = i_q + 8'd1;
          data_d = i_q + 8'd1;
          wren_d = 1'b1;
        end
      end
`endif
      ST_RD_SI, ST_WT_SI: begin
        if ((MEM_RD_LAT == 0) || ((state_q == ST_WT_SI) && (wcnt_q == WAIT_LAST))) begin
          si_d    = s_q;
          j_d     = j_new_s;
          addr_d  = j_new_s;
          state_d = ST_RD_SJ;
        end else begin
          wcnt_d  = (state_q == ST_RD_SI) ? 2'd0 : wcnt_q + 2'd1;
          state_d = ST_WT_SI;
        end
      end
      ST_RD_SJ, ST_WT_SJ: begin
        if ((MEM_RD_LAT == 0) || ((state_q == ST_WT_SJ) && (wcnt_q == WAIT_LAST))) begin
          addr_d  = i_q;
          data_d  = s_q;
          wren_d  = 1'b1;
          state_d = ST_WR_SI;
        end else begin
          wcnt_d  = (state_q == ST_RD_SJ) ? 2'd0 : wcnt_q + 2'd1;
          state_d = ST_WT_SJ;
        end
      end
      ST_WR_SI: begin
        addr_d  = j_q;
        data_d  = si_q;
        wren_d  = 1'b1;
        state_d = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        if (i_q == 8'd255) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KW'(1);
          addr_d  = i_q + 8'd1;
          state_d = ST_RD_SI;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign s_address = addr_q;
  assign s_data    = data_q;
  assign s_wren    = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three instances (latency 0/1/2, 3- and 16-byte keys), each with its own S RAM model.
module tb_rc4_ksa_engine;

  localparam int NI = 3;
`ifdef RC4_KSA_INIT_EN
  localparam int INIT_CYC = 256;
`else
  localparam int INIT_CYC = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_s [NI];
  logic [127:0] key_s   [NI];
  logic [7:0]   q_s     [NI];
  logic [7:0]   addr_s  [NI];
  logic [7:0]   data_s  [NI];
  logic         wren_s  [NI];
  logic         busy_s  [NI];
  logic         done_s  [NI];
  logic         fill_en [NI];
  logic [7:0]   mem     [NI][256];
  logic [7:0]   p1      [NI];
  logic [7:0]   p2      [NI];
  logic [7:0]   ref_s   [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int KB = (g == 2) ? 16 : 3;
    rc4_ksa_engine #(.KEY_BYTES(KB), .MEM_RD_LAT(g)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start_s[g]),
      .secret_key (key_s[g][8*KB-1:0]),
      .s_q        (q_s[g]),
      .s_address  (addr_s[g]),
      .s_data     (data_s[g]),
      .s_wren     (wren_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g])
    );
  end

  // S RAMs with 0/1/2-cycle read latency; a fill preloads identity (or 8'hA5 when the engine self-fills).
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (fill_en[g]) begin
        for (int k = 0; k < 256; k++) mem[g][k] <= (INIT_CYC != 0) ? 8'hA5 : 8'(k);
      end else if (wren_s[g]) begin
        mem[g][addr_s[g]] <= data_s[g];
      end
      p1[g] <= mem[g][addr_s[g]];
      p2[g] <= p1[g];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      q_s[g] = (g == 0) ? mem[g][addr_s[g]] : ((g == 1) ? p1[g] : p2[g]);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Textbook RC4 KSA over the first kb bytes of key (byte 0 = most significant).
  task automatic model(input logic [127:0] key, input int kb);
    int s[256];
    int jj;
    int t;
    for (int k = 0; k < 256; k++) s[k] = k;
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      jj = (jj + s[ii] + int'(key[8*(kb-1-(ii % kb)) +: 8])) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
    end
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(s[k]);
  endtask

  function automatic int s_errors(input int g);
    int e = 0;
    for (int k = 0; k < 256; k++) if (mem[g][k] !== ref_s[k]) e++;
    return e;
  endfunction

  task automatic fill(input int g);
    fill_en[g] = 1'b1;
    @(posedge clk); #1;
    fill_en[g] = 1'b0;
  endtask

  task automatic do_run(input int g, input logic [127:0] key, input int exp_n, input bit hold, input bit jitter);
    int cyc;
    int bad;
    fill(g);
    key_s[g]   = key;
    start_s[g] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    bad = 0;
    check("busy_after_start", int'(busy_s[g]), 1);
    if (!hold) start_s[g] = 1'b0;
    while (!done_s[g] && cyc < exp_n + 64) begin
      if (jitter) begin
        start_s[g] = 1'($urandom_range(0, 1));
        key_s[g]   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      cyc++;
      if (wren_s[g] && !busy_s[g]) bad++;
    end
    check("cycles_to_done", cyc, exp_n);
    check("busy_at_done", int'(busy_s[g]), 0);
    check("wren_at_done", int'(wren_s[g]), 0);
    check("wren_outside_busy", bad, 0);
    model(key, (g == 2) ? 16 : 3);
    check("final_S_errors", s_errors(g), 0);
    if (!hold) begin
      start_s[g] = 1'b0;
      @(posedge clk); #1;
      check("done_cleared", int'(done_s[g]), 0);
    end
  endtask

  typedef struct {
    int           inst;
    logic [127:0] key;
    int           n;
    bit           jitter;
  } vec_t;

  vec_t vt[6];

  initial begin
    int r;
    vt[0] = '{0, 128'h000249, 1024 + INIT_CYC, 1'b0};
    vt[1] = '{1, 128'h000000, 1536 + INIT_CYC, 1'b0};
    vt[2] = '{2, 128'h0102030405060708090a0b0c0d0e0f10, 2048 + INIT_CYC, 1'b0};
    for (int v = 3; v < 6; v++) begin
      r = int'($urandom_range(0, 2));
      vt[v] = '{r, {$urandom, $urandom, $urandom, $urandom}, 256 * (4 + 2 * r) + INIT_CYC, 1'b1};
    end

    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      key_s[g]   = '0;
      fill_en[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check("reset_outputs", int'({addr_s[g], data_s[g], wren_s[g], busy_s[g], done_s[g]}), 0);
    end
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) do_run(vt[v].inst, vt[v].key, vt[v].n, 1'b0, vt[v].jitter);

    // start held high across completion: done must stay, no new run may begin.
    do_run(0, 128'h00abcdef, 1024 + INIT_CYC, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_done_stays", int'(done_s[0]), 1);
    check("hold_no_busy", int'(busy_s[0]), 0);
    check("hold_S_untouched", s_errors(0), 0);
    fill(0);
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    check("hold_done_clears", int'(done_s[0]), 0);
    do_run(0, 128'h00abcdef, 1024 + INIT_CYC, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    fill(1);
    key_s[1]   = 128'h5a17c3;
    start_s[1] = 1'b1;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    check("busy_before_abort", int'(busy_s[1]), 1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", int'({addr_s[1], data_s[1], wren_s[1], busy_s[1], done_s[1]}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_run(1, 128'h5a17c3, 1536 + INIT_CYC, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Parametrised RC4 key-scheduling (KSA) engine that permutes the 256-byte S memory in place, driven by a secret key of KEY_BYTES bytes.
- Sits between the top-level key source / brute-force controller and the single-port S on-chip RAM.
- Successor to the fixed 3-byte, zero-latency KSA stage: generalised key length, configurable RAM read latency, four-phase start/done handshake, optional built-in S[i]=i fill.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32); secret_key width is 8*KEY_BYTES.
- MEM_RD_LAT, 1, S RAM read latency in cycles (0, 1 or 2); s_q is valid MEM_RD_LAT cycles after s_address is driven.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; level-sampled in IDLE.
- secret_key  in  8*KEY_BYTES  key; key[0] = most significant byte; latched when start is accepted.
- s_q  in  8  S RAM read data.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- busy  out  1  high from start acceptance until done rises.
- done  out  1  completion flag, four-phase handshake.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; s_address=0, s_data=0, s_wren=0, busy=0, done=0; internal i=0, j=0, key register cleared.
- Algorithm: j=0; for i=0..255: j=(j+S[i]+key[i mod KEY_BYTES]) mod 256; swap S[i],S[j]. All index/sum arithmetic is 8-bit wrap-around.
- Key index is a counter that resets to 0 when it reaches KEY_BYTES-1. No divider is used.
- States: IDLE, [INIT], RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, DONE.
- IDLE: if start=1 at a rising edge, latch secret_key, clear i/j, set busy=1, and go to INIT (macro on) or RD_SI.
- RD_SI: s_address=i, s_wren=0. After MEM_RD_LAT cycles (WT_SI counter; zero cycles when MEM_RD_LAT=0, s_q sampled in RD_SI itself), capture si=s_q and compute j_new. Go to RD_SJ.
- RD_SJ / WT_SJ: same pattern with address j_new; capture sj.
- WR_SI: s_address=i, s_data=sj, s_wren=1.
- WR_SJ: s_address=j, s_data=si, s_wren=1. If i=255, go to DONE; else i++ and go to RD_SI.
- i==j: both writes target the same address with the same value; S stays unchanged. No special casing.
- Per-iteration cost: 4+2*MEM_RD_LAT cycles. N = 256*(4+2*MEM_RD_LAT) (+256 with the optional feature) cycles from the start-sampling edge to the edge after which done=1.
- DONE: done=1, busy=0, s_wren=0. Hold until start=0, then return to IDLE and clear done on the same edge.
- start toggled or held while busy: ignored. secret_key changes while busy: ignored (latched copy is used).
- reset_n asserted mid-run: immediate abort to IDLE with all outputs at reset values. S contents are left partially permuted; clearing them is the caller's job.
- s_wren is never high in IDLE, DONE, RD_*, or WT_* states.

Optional Feature:
- RC4_KSA_INIT_EN defined: adds an INIT state after start acceptance. It performs 256 consecutive writes s_address=k, s_data=k, s_wren=1 for k=0..255 (one per cycle), then enters RD_SI with i=j=0. Adds exactly 256 cycles to N.
- Not defined: no INIT state. The S RAM must already hold the identity permutation before start.

Test Plan:
- KEY_BYTES=3, MEM_RD_LAT=0, S preloaded to identity, key 24'h000249 -> final S matches a software RC4 KSA model byte-for-byte; done rises 1024 cycles after the start edge.
- MEM_RD_LAT=1, key 24'h000000 -> iteration 0 is a self-swap (j=0, S[0] unchanged); final S matches model; N=1536.
- RC4_KSA_INIT_EN, MEM_RD_LAT=2, S preloaded with 8'hA5, key 24'h123456 -> final S matches model from identity; N=2048+256=2304.
- KEY_BYTES=16, key 128'h0102...10 -> key index wraps 15->0; final S matches model.
- Hold start=1 after done -> done stays 1 and no new run starts; drop start -> done=0 next edge; re-raise start -> second run gives the same S.
- Pulse reset_n low at cycle 500 of a run -> outputs return to 0 asynchronously; new start with re-identity S -> correct final S.
